// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALUOp, alucontrol, states.
// ORI support (op 001101) is compiled in only when MIPS_CTRL_ORI_EN is defined.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b010;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b110;
    localparam logic [ALUC_W-1:0] ALUC_AND = 3'b000;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b001;
    localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
`ifdef MIPS_CTRL_ORI_EN
        S_ORIEX   = 4'd12,
        S_ORIWB   = 4'd13,
`endif
        S_JUMP    = 4'd11
    } state_e;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps ALUOp (and funct in funct-mode) to the 3-bit alucontrol code.
module mips_aludec
    import mips_ctrl_pkg::*;
(
    input  logic [1:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [ALUC_W-1:0]  alucontrol
);

    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUC_ADD;
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_OR:  alucontrol = ALUC_OR;
            default: begin
                // Unknown functs fall back to add; regwrite is decided by the FSM, not here.
                case (funct)
                    FN_ADD:  alucontrol = ALUC_ADD;
                    FN_SUB:  alucontrol = ALUC_SUB;
                    FN_AND:  alucontrol = ALUC_AND;
                    FN_OR:   alucontrol = ALUC_OR;
                    FN_SLT:  alucontrol = ALUC_SLT;
                    default: alucontrol = ALUC_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: state flop, next-state logic, Moore output decode, pcen gate.
// Define MIPS_CTRL_ORI_EN to add the ori path (ORIEX/ORIWB, immzx).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    output logic               pcen,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic [1:0]         pcsrc,
    output logic [ALUC_W-1:0]  alucontrol,
    output logic               immzx
);

    state_e      state_q, state_d;
    logic        pcwrite, branch;
    logic [1:0]  aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = S_FETCH;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;
        immzx    = 1'b0;
        case (state_q)
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ORI_EN
                    OP_ORI:       state_d = S_ORIEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MIPS_CTRL_ORI_EN
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                immzx   = 1'b1;
                aluop   = ALUOP_OR;
                state_d = S_ORIWB;
            end
            S_ORIWB: regwrite = 1'b1;
`endif
            // FETCH, and any code outside the state set, behaves as FETCH.
            default: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
        endcase
    end

    assign pcen = pcwrite | (branch & zero);

    mips_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: random instruction stream vs. a per-cycle
// output model built from instruction class and cycle index, plus async reset aborts.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, immzx;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [15:0] got;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord), .memtoreg(memtoreg),
        .regdst(regdst), .pcsrc(pcsrc), .alucontrol(alucontrol), .immzx(immzx)
    );

    assign got = {pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
                  memtoreg, regdst, pcsrc, alucontrol, immzx};

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (pcen,mw,irw,rw,srca,srcb2,iord,m2r,rdst,pcsrc2,aluc3,immzx)",
                     tag, act, req);
        end
    endtask

    function automatic bit ori_en();
`ifdef MIPS_CTRL_ORI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int latency(input logic [5:0] o);
        case (o)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            6'b001101: return ori_en() ? 4 : 2;
            default:   return 2;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs in cycle k (0-based) of an instruction with opcode o.
    function automatic logic [15:0] exp_out(input logic [5:0] o, input logic [5:0] f,
                                            input logic z, input int k);
        logic pe = 0, mw = 0, irw = 0, rw = 0, sa = 0, io = 0, m2r = 0, rd = 0, zx = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] ac = 3'b010;
        if (k == 0) begin
            pe = 1; irw = 1; sb = 2'b01;
        end else if (k == 1) begin
            sb = 2'b11;
        end else begin
            case (o)
                6'b100011: case (k)
                    2: begin sa = 1; sb = 2'b10; end
                    3: io = 1;
                    default: begin m2r = 1; rw = 1; end
                endcase
                6'b101011: if (k == 2) begin sa = 1; sb = 2'b10; end
                           else begin io = 1; mw = 1; end
                6'b000000: if (k == 2) begin sa = 1; ac = funct_alu(f); end
                           else begin rd = 1; rw = 1; end
                6'b000100: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
                6'b001000: if (k == 2) begin sa = 1; sb = 2'b10; end
                           else rw = 1;
                6'b000010: begin ps = 2'b10; pe = 1; end
                default: if (k == 2) begin sa = 1; sb = 2'b10; zx = 1; ac = 3'b001; end
                         else rw = 1;
            endcase
        end
        return {pe, mw, irw, rw, sa, sb, io, m2r, rd, ps, ac, zx};
    endfunction

    // Runs one instruction from FETCH, entered and left at a falling edge.
    // zmode 0/1 forces zero, 2 randomises it; abort_k >= 0 pulses reset in that cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                             input int abort_k);
        op = o; funct = f;
        for (int k = 0; k < latency(o); k++) begin
            zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1 check_eq($sformatf("op%b_f%b_k%0d", o, f, k), got, exp_out(o, f, zero, k));
            if (k == abort_k) begin
                #1 reset = 1'b1;
                #1 check_eq("reset_async", got, exp_out(o, f, zero, 0));
                @(negedge clk);
                check_eq("reset_held", got, exp_out(o, f, zero, 0));
                reset = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    logic [5:0] legal_ops [7];
    logic [5:0] known_fn [5];

    initial begin
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b001101};
        known_fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
        #1 check_eq("reset_initial", got, exp_out(6'd0, 6'd0, 1'b0, 0));
        repeat (2) @(negedge clk);
        check_eq("reset_before_release", got, exp_out(6'd0, 6'd0, 1'b0, 0));
        reset = 1'b0;

        run_instr(6'b100011, 6'd0,      2, -1);
        run_instr(6'b101011, 6'd0,      2, -1);
        run_instr(6'b000000, 6'b100010, 2, -1);
        run_instr(6'b000100, 6'd0,      1, -1);
        run_instr(6'b000100, 6'd0,      0, -1);
        run_instr(6'b111111, 6'd0,      2, -1);
        run_instr(6'b001101, 6'd0,      2, -1);
        run_instr(6'b000010, 6'd0,      2, -1);

        for (int i = 0; i < 200; i++) begin
            int sel;
            logic [5:0] o, f;
            sel = int'($urandom_range(0, 8));
            o = (sel < 7) ? legal_ops[sel] : 6'($urandom);
            f = ($urandom_range(0, 1) == 0) ? known_fn[$urandom_range(0, 4)] : 6'($urandom);
            run_instr(o, f, 2, -1);
        end

        // Reset aborts during MEMWR and MEMWB, then a clean instruction must follow.
        run_instr(6'b101011, 6'd0, 2, 3);
        run_instr(6'b000000, 6'b101010, 2, -1);
        run_instr(6'b100011, 6'd0, 2, 4);
        run_instr(6'b001000, 6'd0, 2, 1);
        run_instr(6'b100011, 6'd0, 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
